dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Initiator side of the data-memory interface: accepts load/store requests from the datapath over valid/ready and drives the memory's write-enable, read-enable, address and write-data lines.
- Captures the memory's combinational read data into a registered response channel with backpressure.
- Supports single-word stores and incrementing-address read bursts of 1 to 16 words.
- Sits between the datapath and the 16x16 data memory.

Parameters:
ADDR_W, 4, memory address width (16 words)
DATA_W, 16, data word width
LEN_W, 4, burst length field width; a burst is req_len+1 words

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid and req_ready are both high
req_write  input  1  1=store, 0=load burst
req_addr  input  ADDR_W  start address
req_wdata  input  DATA_W  store data
req_len  input  LEN_W  read beats minus 1 (ignored on store)
rsp_valid  output  1  read data available
rsp_ready  input  1  consumer accepts rsp_data
rsp_data  output  DATA_W  registered read word
rsp_last  output  1  final beat of burst
wr_done  output  1  one-cycle pulse when a store completes
err  output  1  sticky verify mismatch (see Optional Feature)
mem_write  output  1  to memory MemWrite
mem_read  output  1  to memory MemRead
mem_addr  output  ADDR_W  to memory Address
mem_wdata  output  DATA_W  to memory WriteData
mem_rdata  input  DATA_W  from memory ReadData, combinational from mem_addr

Behaviour:
- Reset (async, active-high): state=IDLE; every output is 0 (req_ready=0 while reset is asserted). Reset mid-burst or mid-store aborts the operation; no response or wr_done is produced.
- States: IDLE, WRITE, READ, RESP (plus VERIFY when the optional feature is enabled).
- IDLE:
  - req_ready=1.
  - On handshake, latch addr, wdata and len; clear the beat counter.
  - req_write=1 -> WRITE; req_write=0 -> READ.
- WRITE (1 cycle):
  - mem_write=1, mem_addr=latched addr, mem_wdata=latched data.
  - Next: IDLE, with wr_done=1 for exactly that next cycle.
  - Store latency: handshake to wr_done = 2 cycles.
- READ (1 cycle):
  - mem_read=1, mem_addr=current addr.
  - At the clock edge, rsp_data<=mem_rdata; rsp_valid<=1; rsp_last<=(beat==len).
  - Next: RESP.
- RESP:
  - Hold rsp_data, rsp_valid and rsp_last stable until rsp_ready.
  - On rsp_ready: rsp_valid<=0. If rsp_last, go to IDLE; otherwise addr<=addr+1 (mod 2^ADDR_W, so 15 wraps to 0), beat<=beat+1, go to READ.
  - Throughput: 2 cycles per beat when rsp_ready is held high.
- mem_write and mem_read are never both 1. Both are 0 in IDLE and RESP. mem_addr and mem_wdata are 0 whenever both enables are 0.
- req_ready=0 in every state except IDLE. A request presented while busy is held by the requester and is not lost.
- len=15 produces 16 beats covering every address exactly once, starting from req_addr and wrapping.
- rsp_ready high while rsp_valid=0 has no effect.

Optional Feature:
Macro DMEM_WRITE_VERIFY_EN.
- Defined:
  - WRITE is followed by a VERIFY cycle: mem_read=1 at the latched addr, and mem_rdata is compared with the latched wdata.
  - On mismatch, err<=1. err is sticky and cleared only by reset.
  - wr_done pulses on the cycle after VERIFY, so store latency is 3 cycles.
- Undefined:
  - No VERIFY state; err is tied to 0; store latency is 2 cycles.

Test Plan:
- Reset, then store addr=3 data=0xBEEF -> mem_write=1 for one cycle with mem_addr=3 and mem_wdata=0xBEEF; wr_done pulses 2 cycles after handshake (3 if DMEM_WRITE_VERIFY_EN); err=0.
- Preload addr 5..7 = 0x1111/0x2222/0x3333; load addr=5 len=2 with rsp_ready=1 -> three beats 0x1111, 0x2222, 0x3333, each 2 cycles apart; rsp_last only on 0x3333; then back to IDLE.
- Load addr=14 len=3 -> mem_addr sequence 14, 15, 0, 1 (wrap); rsp_last on the beat from address 1.
- Load len=1 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data held constant, mem_read=0, req_ready=0; first beat delivered when rsp_ready rises.
- Assert reset during RESP of a 4-beat burst -> all outputs 0 immediately; after release, req_ready=1 and no stale rsp_valid.
- DMEM_WRITE_VERIFY_EN build: force mem_rdata=0x0000 during VERIFY of store 0xA5A5 -> err=1 and stays 1 across later good stores until reset.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory initiator: single-word stores and incrementing read bursts with a registered response channel.
// Optional write-verify read-back cycle enabled by defining DMEM_WRITE_VERIFY_EN.
module dmem_access_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              wr_done,
    output logic              err,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RESP
`ifdef DMEM_WRITE_VERIFY_EN
        , VERIFY
`endif
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  beat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid)
                    state_nxt = req_write ? WRITE : READ;
            end
`ifdef DMEM_WRITE_VERIFY_EN
            WRITE:  state_nxt = VERIFY;
            VERIFY: state_nxt = IDLE;
`else
            WRITE:  state_nxt = IDLE;
`endif
            READ:   state_nxt = RESP;
            RESP: begin
                if (rsp_ready)
                    state_nxt = rsp_last ? IDLE : READ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address and write data are forced to zero whenever no enable is active.
    always_comb begin
        req_ready = (state == IDLE) && !reset;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            WRITE: begin
                mem_write = 1'b1;
                mem_addr  = addr;
                mem_wdata = wdata;
            end
            READ: begin
                mem_read = 1'b1;
                mem_addr = addr;
            end
`ifdef DMEM_WRITE_VERIFY_EN
            VERIFY: begin
                mem_read = 1'b1;
                mem_addr = addr;
            end
`endif
            default: begin
                mem_write = 1'b0;
            end
        endcase
    end

`ifdef DMEM_WRITE_VERIFY_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Request latches, burst bookkeeping and the registered response channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            wdata     <= '0;
            len       <= '0;
            beat      <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            wr_done   <= 1'b0;
`ifdef DMEM_WRITE_VERIFY_EN
            err_q     <= 1'b0;
`endif
        end else begin
            wr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr  <= req_addr;
                        wdata <= req_wdata;
                        len   <= req_len;
                        beat  <= '0;
                    end
                end
                WRITE: begin
`ifndef DMEM_WRITE_VERIFY_EN
                    wr_done <= 1'b1;
`endif
                end
`ifdef DMEM_WRITE_VERIFY_EN
                VERIFY: begin
                    if (mem_rdata != wdata)
                        err_q <= 1'b1;
                    wr_done <= 1'b1;
                end
`endif
                READ: begin
                    rsp_data  <= mem_rdata;
                    rsp_valid <= 1'b1;
                    rsp_last  <= (beat == len);
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        if (!rsp_last) begin
                            addr <= addr + 1'b1;
                            beat <= beat + 1'b1;
                        end
                    end
                end
                default: begin
                    wr_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: stimulus queues expected memory/response activity, a monitor checks it.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic [3:0]  req_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_last;
    logic        wr_done;
    logic        err;
    logic        mem_write;
    logic        mem_read;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

`ifdef DMEM_WRITE_VERIFY_EN
    localparam int LAT = 3;
    localparam logic ERR_AFTER_BAD = 1'b1;
`else
    localparam int LAT = 2;
    localparam logic ERR_AFTER_BAD = 1'b0;
`endif

    dmem_access_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .wr_done   (wr_done),
        .err       (err),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 16x16 memory; force_zero corrupts the read-back path.
    logic [15:0] mem [16];
    logic        force_zero = 1'b0;
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = force_zero ? 16'h0000 : mem[mem_addr];

    logic [19:0] wq[$];
    int          wdone_q[$];
    logic [3:0]  raddr_q[$];
    logic [16:0] rsp_q[$];
    int          rspcyc_q[$];
    logic [15:0] expw [16];

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic noteUnexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got unexpected activity required none (cycle %0d)", name, cyc);
    endtask

    logic [19:0] mw;
    logic [16:0] mr;
    logic [3:0]  ma;
    int          mc;

    always @(negedge clk) begin : monitor
        if (!reset) begin
            if (mem_write || mem_read)
                checkOutput("mem_excl", 32'(mem_write & mem_read), 32'd0);
            if (mem_write) begin
                if (wq.size() == 0) noteUnexpected("mem_write");
                else begin
                    mw = wq.pop_front();
                    checkOutput("wr_addr", 32'(mem_addr), 32'(mw[19:16]));
                    checkOutput("wr_data", 32'(mem_wdata), 32'(mw[15:0]));
                end
            end
            if (mem_read) begin
                if (raddr_q.size() == 0) noteUnexpected("mem_read");
                else begin
                    ma = raddr_q.pop_front();
                    checkOutput("rd_addr", 32'(mem_addr), 32'(ma));
                end
            end
            if (wr_done) begin
                if (wdone_q.size() == 0) noteUnexpected("wr_done");
                else begin
                    mc = wdone_q.pop_front();
                    checkOutput("wr_done_cycle", 32'(cyc), 32'(mc));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) noteUnexpected("rsp_valid");
                else begin
                    mr = rsp_q.pop_front();
                    mc = rspcyc_q.pop_front();
                    checkOutput("rsp_data", 32'(rsp_data), 32'(mr[15:0]));
                    checkOutput("rsp_last", 32'(rsp_last), 32'(mr[16]));
                    if (mc >= 0) checkOutput("rsp_cycle", 32'(cyc), 32'(mc));
                end
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [3:0] a, input logic [15:0] d,
                                 input logic [3:0] l, output int hcyc);
        bit got = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_len   = l;
        hcyc      = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got  = 1;
                hcyc = cyc;
                break;
            end
        end
        if (!got) noteUnexpected("req_ready_timeout");
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        bit done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready && wq.size() == 0 && wdone_q.size() == 0 &&
                raddr_q.size() == 0 && rsp_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) noteUnexpected("idle_timeout");
    endtask

    task automatic doStore(input logic [3:0] a, input logic [15:0] d);
        int c;
        applyStimulus(1'b1, a, d, 4'd0, c);
        wq.push_back({a, d});
        wdone_q.push_back(c + LAT);
`ifdef DMEM_WRITE_VERIFY_EN
        raddr_q.push_back(a);
`endif
        waitIdle();
    endtask

    task automatic doLoad(input logic [3:0] a, input logic [3:0] l, input bit timed);
        int c;
        applyStimulus(1'b0, a, 16'h0000, l, c);
        for (int k = 0; k <= int'(l); k++) begin
            raddr_q.push_back(4'(a + 4'(k)));
            rsp_q.push_back({(k == int'(l)), expw[k]});
            rspcyc_q.push_back(timed ? c + 2 + 2 * k : -1);
        end
    endtask

    task automatic waitRspValid();
        bit seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) noteUnexpected("rsp_valid_timeout");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_len   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp", 32'({rsp_valid, rsp_last, wr_done, err}), 32'd0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_mem_en", 32'({mem_write, mem_read}), 32'd0);
        checkOutput("rst_mem_bus", 32'({mem_addr, mem_wdata}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_req_ready", 32'(req_ready), 32'd1);

        doStore(4'd3, 16'hBEEF);
        checkOutput("err_after_store", 32'(err), 32'd0);
        doStore(4'd5, 16'h1111);
        doStore(4'd6, 16'h2222);
        doStore(4'd7, 16'h3333);
        doStore(4'd14, 16'h0E0E);
        doStore(4'd15, 16'h0F0F);
        doStore(4'd0, 16'h0A0A);
        doStore(4'd1, 16'h0B0B);

        expw[0] = 16'h1111; expw[1] = 16'h2222; expw[2] = 16'h3333;
        doLoad(4'd5, 4'd2, 1'b1);
        waitIdle();

        expw[0] = 16'h0E0E; expw[1] = 16'h0F0F; expw[2] = 16'h0A0A; expw[3] = 16'h0B0B;
        doLoad(4'd14, 4'd3, 1'b1);
        waitIdle();

        // Backpressure: response must freeze while the consumer stalls.
        rsp_ready = 1'b0;
        expw[0] = 16'h1111; expw[1] = 16'h2222;
        doLoad(4'd5, 4'd1, 1'b0);
        waitRspValid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rsp_data", 32'(rsp_data), 32'h1111);
            checkOutput("bp_mem_read", 32'(mem_read), 32'd0);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        waitIdle();

        // Reset in the middle of a 4-beat burst.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 4'd14, 16'h0000, 4'd3, c);
        raddr_q.push_back(4'd14);
        waitRspValid();
        checkOutput("abort_first_beat", 32'(rsp_data), 32'h0E0E);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_req_ready", 32'(req_ready), 32'd0);
        checkOutput("abort_rsp", 32'({rsp_valid, rsp_last, wr_done, err}), 32'd0);
        checkOutput("abort_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("abort_mem", 32'({mem_write, mem_read, mem_addr}), 32'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_abort_ready", 32'(req_ready), 32'd1);
            checkOutput("post_abort_valid", 32'(rsp_valid), 32'd0);
        end

        // Corrupted read-back during the store of 0xA5A5.
        force_zero = 1'b1;
        doStore(4'd9, 16'hA5A5);
        force_zero = 1'b0;
        checkOutput("err_after_bad", 32'(err), 32'(ERR_AFTER_BAD));
        doStore(4'd10, 16'h1234);
        checkOutput("err_sticky", 32'(err), 32'(ERR_AFTER_BAD));
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("err_cleared", 32'(err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);

        checkOutput("wq_empty", 32'(wq.size()), 32'd0);
        checkOutput("wdone_q_empty", 32'(wdone_q.size()), 32'd0);
        checkOutput("raddr_q_empty", 32'(raddr_q.size()), 32'd0);
        checkOutput("rsp_q_empty", 32'(rsp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
